// File: rtl/wr_fence_sequencer_if.sv
// wr_fence_sequencer_if: request bus and SPL TX write channel of wr_fence_sequencer
// master: upstream request source / SPL side model; slave: wr_fence_sequencer
interface wr_fence_sequencer_if;
  logic         in_valid;
  logic         in_fence;
  logic [57:0]  in_addr;
  logic [511:0] in_data;
  logic         in_afull;
  logic         spl_tx_wr_almostfull;
  logic         io_tx_wr_valid;
  logic         io_tx_fence_valid;
  logic [57:0]  io_tx_wr_addr;
  logic [5:0]   io_tx_wr_len;
  logic [511:0] io_tx_data;
  modport master (
    output in_valid, in_fence, in_addr, in_data, spl_tx_wr_almostfull,
    input  in_afull, io_tx_wr_valid, io_tx_fence_valid, io_tx_wr_addr, io_tx_wr_len, io_tx_data
  );
  modport slave (
    input  in_valid, in_fence, in_addr, in_data, spl_tx_wr_almostfull,
    output in_afull, io_tx_wr_valid, io_tx_fence_valid, io_tx_wr_addr, io_tx_wr_len, io_tx_data
  );
endinterface

// File: rtl/wr_fence_sequencer.sv
// wr_fence_sequencer: in-order write/fence FIFO feeding the SPL TX write channel with post-fence quiet gap
// Ports: CLK_400M, reset_n (async, active-low), clear (sync, keeps overflow),
//   bus (slave: in_* request side, in_afull, spl_tx_wr_almostfull, io_tx_* issue side),
//   wr_count / fence_count issue counters, sticky overflow.
// Option: define WR_SEQ_FENCE_MERGE_EN to drop a fence that directly follows an issued fence.
module wr_fence_sequencer #(
  parameter int         DEPTH     = 16,
  parameter int         FENCE_GAP = 4,
  parameter logic [5:0] WR_LEN    = 6'd1
) (
  input  logic                       CLK_400M,
  input  logic                       reset_n,
  input  logic                       clear,
  wr_fence_sequencer_if.slave        bus,
  output logic [31:0]                wr_count,
  output logic [15:0]                fence_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
`ifdef WR_SEQ_FENCE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  typedef enum logic {ISSUE, GAP} state_t;
  state_t        state;
  logic [570:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic [3:0]    gap_cnt;
  logic          last_fence;
  logic          full, empty, push, pop, drop;
  logic [570:0]  head;
  assign full = occ == (AW+1)'(DEPTH);
  assign empty = occ == '0;
  assign push = bus.in_valid && !full && !clear;
  assign pop = state == ISSUE && !empty && !bus.spl_tx_wr_almostfull && !clear;
  assign head = mem[rd_ptr];
  // a merged fence still pops, but issues nothing and starts no gap
  assign drop = MERGE && last_fence;
  assign bus.in_afull = occ >= (AW+1)'(DEPTH - 2);
  assign bus.io_tx_wr_len = WR_LEN;
  always_ff @(posedge CLK_400M)
    if (push) mem[wr_ptr] <= {bus.in_fence, bus.in_addr, bus.in_data};
  // overflow survives clear; only reset_n clears it
  always_ff @(posedge CLK_400M or negedge reset_n)
    if (!reset_n) overflow <= 1'b0;
    else if (bus.in_valid && full) overflow <= 1'b1;
  always_ff @(posedge CLK_400M or negedge reset_n)
    if (!reset_n) begin
      state                 <= ISSUE;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      occ                   <= '0;
      gap_cnt               <= '0;
      last_fence            <= 1'b0;
      wr_count              <= '0;
      fence_count           <= '0;
      bus.io_tx_wr_valid    <= 1'b0;
      bus.io_tx_fence_valid <= 1'b0;
      bus.io_tx_wr_addr     <= '0;
      bus.io_tx_data        <= '0;
    end else if (clear) begin
      state                 <= ISSUE;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      occ                   <= '0;
      gap_cnt               <= '0;
      last_fence            <= 1'b0;
      wr_count              <= '0;
      fence_count           <= '0;
      bus.io_tx_wr_valid    <= 1'b0;
      bus.io_tx_fence_valid <= 1'b0;
      bus.io_tx_wr_addr     <= '0;
      bus.io_tx_data        <= '0;
    end else begin
      bus.io_tx_wr_valid    <= 1'b0;
      bus.io_tx_fence_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (state == GAP) begin
        state   <= gap_cnt == '0 ? ISSUE : GAP;
        gap_cnt <= gap_cnt - 4'd1;
      end else if (pop && head[570] && !drop) begin
        bus.io_tx_fence_valid <= 1'b1;
        bus.io_tx_wr_addr     <= '0;
        bus.io_tx_data        <= '0;
        fence_count           <= fence_count + 16'd1;
        last_fence            <= 1'b1;
        state                 <= FENCE_GAP > 0 ? GAP : ISSUE;
        gap_cnt               <= 4'(FENCE_GAP - 1);
      end else if (pop && !head[570]) begin
        bus.io_tx_wr_valid <= 1'b1;
        bus.io_tx_wr_addr  <= head[569:512];
        bus.io_tx_data     <= head[511:0];
        wr_count           <= wr_count + 32'd1;
        last_fence         <= 1'b0;
      end
    end
endmodule
